// File: rtl/countdown_timer_with_alarm_pkg.sv
// Shared definitions for the mm:ss countdown timer.
//   - FSM state encodings (also driven onto the 3-bit state output)
//   - command codes carried on {switch2, switch1, switch0}
//   - BCD digit type and digit limits
//   - small BCD / 7-segment helper functions
package countdown_timer_with_alarm_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_RUN   = 3'b001,
        S_PAUSE = 3'b010,
        S_SET   = 3'b011,
        S_DONE  = 3'b100
    } state_t;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_IDLE  = 3'b000;
    localparam cmd_t CMD_RUN   = 3'b001;
    localparam cmd_t CMD_PAUSE = 3'b010;
    localparam cmd_t CMD_CLEAR = 3'b011;
    localparam cmd_t CMD_SET   = 3'b100;

    typedef logic [3:0] bcd_t;

    localparam bcd_t MAX_TENS  = 4'd5;
    localparam bcd_t MAX_UNITS = 4'd9;

    // Tens digit of a 0..99 integer (used to build preset constants).
    function automatic bcd_t tens_of(input int unsigned v);
        return bcd_t'((v / 32'd10) % 32'd10);
    endfunction

    // Units digit of a 0..99 integer.
    function automatic bcd_t units_of(input int unsigned v);
        return bcd_t'(v % 32'd10);
    endfunction

    // Increment a two-digit BCD field that wraps 59 -> 00.
    // Result is {tens, units}.
    function automatic logic [7:0] bcd_inc59(input bcd_t tens, input bcd_t units);
        if (units != MAX_UNITS) begin
            return {tens, units + 4'd1};
        end else if (tens != MAX_TENS) begin
            return {tens + 4'd1, 4'd0};
        end else begin
            return 8'h00;
        end
    endfunction

    // Active-high 7-segment pattern, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_encode(input bcd_t d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/countdown_timer_with_alarm_bcd_down_counter.sv
// bcd_down_counter: 4-digit mm:ss BCD counter plus its load register.
//   clk, rst          : clock, asynchronous active-low reset
//   dec               : decrement the count by one second (never below 00:00)
//   inc_min / inc_sec : bump the load register minutes / seconds (each wraps 59->00,
//                       no carry between the fields)
//   load              : copy the load register into the count
//   cnt_*             : current count digits
//   ld_*              : load register digits
//   zero              : count is 00:00
//   last              : count is 00:01, i.e. the next decrement reaches 00:00
// Reset puts both the count and the load register at PRESET_MIN:PRESET_SEC.
module bcd_down_counter
    import countdown_timer_with_alarm_pkg::*;
#(
    parameter int unsigned PRESET_MIN = 5,
    parameter int unsigned PRESET_SEC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic dec,
    input  logic inc_min,
    input  logic inc_sec,
    input  logic load,
    output bcd_t cnt_min_t,
    output bcd_t cnt_min_u,
    output bcd_t cnt_sec_t,
    output bcd_t cnt_sec_u,
    output bcd_t ld_min_t,
    output bcd_t ld_min_u,
    output bcd_t ld_sec_t,
    output bcd_t ld_sec_u,
    output logic zero,
    output logic last
);

    localparam bcd_t P_MT = tens_of(PRESET_MIN);
    localparam bcd_t P_MU = units_of(PRESET_MIN);
    localparam bcd_t P_ST = tens_of(PRESET_SEC);
    localparam bcd_t P_SU = units_of(PRESET_SEC);

    bcd_t cnt_mt_r, cnt_mu_r, cnt_st_r, cnt_su_r;
    bcd_t ld_mt_r, ld_mu_r, ld_st_r, ld_su_r;
    bcd_t dec_mt_s, dec_mu_s, dec_st_s, dec_su_s;
    logic zero_s;

    assign zero_s = (cnt_mt_r == 4'd0) && (cnt_mu_r == 4'd0) &&
                    (cnt_st_r == 4'd0) && (cnt_su_r == 4'd0);

    // Borrow chain for one-second decrement; holds at 00:00.
    always_comb begin
        dec_mt_s = cnt_mt_r;
        dec_mu_s = cnt_mu_r;
        dec_st_s = cnt_st_r;
        dec_su_s = cnt_su_r;
        if (zero_s) begin
            dec_su_s = cnt_su_r;
        end else if (cnt_su_r != 4'd0) begin
            dec_su_s = cnt_su_r - 4'd1;
        end else begin
            dec_su_s = MAX_UNITS;
            if (cnt_st_r != 4'd0) begin
                dec_st_s = cnt_st_r - 4'd1;
            end else begin
                dec_st_s = MAX_TENS;
                if (cnt_mu_r != 4'd0) begin
                    dec_mu_s = cnt_mu_r - 4'd1;
                end else begin
                    // Non-zero count with all lower digits zero: min_t is >= 1 here.
                    dec_mu_s = MAX_UNITS;
                    dec_mt_s = cnt_mt_r - 4'd1;
                end
            end
        end
    end

    // Count register: load has priority over decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_mt_r <= P_MT;
            cnt_mu_r <= P_MU;
            cnt_st_r <= P_ST;
            cnt_su_r <= P_SU;
        end else if (load) begin
            cnt_mt_r <= ld_mt_r;
            cnt_mu_r <= ld_mu_r;
            cnt_st_r <= ld_st_r;
            cnt_su_r <= ld_su_r;
        end else if (dec) begin
            cnt_mt_r <= dec_mt_s;
            cnt_mu_r <= dec_mu_s;
            cnt_st_r <= dec_st_s;
            cnt_su_r <= dec_su_s;
        end
    end

    // Load register: independent minute and second fields, each wrapping at 59.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_mt_r <= P_MT;
            ld_mu_r <= P_MU;
            ld_st_r <= P_ST;
            ld_su_r <= P_SU;
        end else begin
            if (inc_sec) begin
                {ld_st_r, ld_su_r} <= bcd_inc59(ld_st_r, ld_su_r);
            end
            if (inc_min) begin
                {ld_mt_r, ld_mu_r} <= bcd_inc59(ld_mt_r, ld_mu_r);
            end
        end
    end

    assign cnt_min_t = cnt_mt_r;
    assign cnt_min_u = cnt_mu_r;
    assign cnt_sec_t = cnt_st_r;
    assign cnt_sec_u = cnt_su_r;
    assign ld_min_t  = ld_mt_r;
    assign ld_min_u  = ld_mu_r;
    assign ld_sec_t  = ld_st_r;
    assign ld_sec_u  = ld_su_r;
    assign zero      = zero_s;
    assign last      = (cnt_mt_r == 4'd0) && (cnt_mu_r == 4'd0) &&
                       (cnt_st_r == 4'd0) && (cnt_su_r == 4'd1);

endmodule

// File: rtl/countdown_timer_with_alarm.sv
// countdown_timer_with_alarm: mm:ss countdown timer with alarm.
// Loads a preset, counts down once per tick to 00:00, then raises alarm.
//   clk          : system clock (single domain, no derived clocks)
//   rst          : asynchronous active-low reset
//   switch0..2   : command word {switch2,switch1,switch0}, synchronised internally
//   btn_min/sec  : load-register increment buttons, effective in SET only
//   seg1..seg4   : registered 7-seg patterns: sec units, sec tens, min units, min tens
//   state        : current FSM state
//   alarm        : countdown expired
//   led          : heartbeat, toggles on every tick
// Build option: define ALARM_BLINK_EN to make the alarm toggle on every tick while
// in DONE (starting at 1 on entry); otherwise alarm is steady 1 in DONE.
module countdown_timer_with_alarm
    import countdown_timer_with_alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned PRESET_MIN = 5,
    parameter int unsigned PRESET_SEC = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       switch0,
    input  logic       switch1,
    input  logic       switch2,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4,
    output logic [2:0] state,
    output logic       alarm,
    output logic       led
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    localparam bcd_t P_MT = tens_of(PRESET_MIN);
    localparam bcd_t P_MU = units_of(PRESET_MIN);
    localparam bcd_t P_ST = tens_of(PRESET_SEC);
    localparam bcd_t P_SU = units_of(PRESET_SEC);

    logic [4:0]    meta_r, sync_r;
    logic [1:0]    btn_prev_r;
    cmd_t          cmd_s;
    logic          min_rise_s, sec_rise_s;

    state_t        state_r, state_nx_s;
    logic [PW-1:0] presc_r;
    logic          tick_s;
    logic          dec_s, load_s, inc_min_s, inc_sec_s;
    logic          alarm_r, led_r;

    bcd_t          cnt_mt_s, cnt_mu_s, cnt_st_s, cnt_su_s;
    bcd_t          ld_mt_s, ld_mu_s, ld_st_s, ld_su_s;
    logic          zero_s, last_s;
    bcd_t          dsp_mt_s, dsp_mu_s, dsp_st_s, dsp_su_s;
    logic [6:0]    seg1_s, seg2_s, seg3_s, seg4_s;
    logic [6:0]    seg1_r, seg2_r, seg3_r, seg4_r;

    // Two-flop synchroniser on every pin, plus previous-value flops for button edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_r     <= 5'd0;
            sync_r     <= 5'd0;
            btn_prev_r <= 2'd0;
        end else begin
            meta_r     <= {btn_sec, btn_min, switch2, switch1, switch0};
            sync_r     <= meta_r;
            btn_prev_r <= sync_r[4:3];
        end
    end

    assign cmd_s      = sync_r[2:0];
    assign min_rise_s = sync_r[3] & ~btn_prev_r[0];
    assign sec_rise_s = sync_r[4] & ~btn_prev_r[1];
    assign tick_s     = (presc_r == PRESC_MAX);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and counter controls. In RUN a pause/clear command suppresses
    // a coincident tick.
    always_comb begin
        state_nx_s = state_r;
        dec_s      = 1'b0;
        load_s     = 1'b0;
        inc_min_s  = 1'b0;
        inc_sec_s  = 1'b0;
        case (state_r)
            S_IDLE: begin
                if ((cmd_s == CMD_RUN) && !zero_s) begin
                    state_nx_s = S_RUN;
                end else if (cmd_s == CMD_SET) begin
                    state_nx_s = S_SET;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (cmd_s == CMD_PAUSE) begin
                    state_nx_s = S_PAUSE;
                end else if (cmd_s == CMD_CLEAR) begin
                    state_nx_s = S_IDLE;
                    load_s     = 1'b1;
                end else if (tick_s) begin
                    dec_s      = 1'b1;
                    state_nx_s = last_s ? S_DONE : S_RUN;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_PAUSE: begin
                if (cmd_s == CMD_RUN) begin
                    state_nx_s = S_RUN;
                end else if (cmd_s == CMD_CLEAR) begin
                    state_nx_s = S_IDLE;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = S_PAUSE;
                end
            end
            S_SET: begin
                inc_min_s = min_rise_s;
                inc_sec_s = sec_rise_s;
                if (cmd_s == CMD_IDLE) begin
                    state_nx_s = S_IDLE;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = S_SET;
                end
            end
            S_DONE: begin
                if (cmd_s == CMD_CLEAR) begin
                    state_nx_s = S_IDLE;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Tick prescaler; restarts on entry to RUN so the first decrement is a full period away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= '0;
        end else if ((state_r != S_RUN) && (state_nx_s == S_RUN)) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Heartbeat LED toggles on every tick regardless of state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_r <= 1'b0;
        end else if (tick_s) begin
            led_r <= ~led_r;
        end
    end

    // Alarm output, registered against the next state so it rises with DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alarm_r <= 1'b0;
        end else begin
`ifdef ALARM_BLINK_EN
            if (state_nx_s != S_DONE) begin
                alarm_r <= 1'b0;
            end else if (state_r != S_DONE) begin
                alarm_r <= 1'b1;
            end else if (tick_s) begin
                alarm_r <= ~alarm_r;
            end
`else
            alarm_r <= (state_nx_s == S_DONE);
`endif
        end
    end

    bcd_down_counter #(
        .PRESET_MIN (PRESET_MIN),
        .PRESET_SEC (PRESET_SEC)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .dec       (dec_s),
        .inc_min   (inc_min_s),
        .inc_sec   (inc_sec_s),
        .load      (load_s),
        .cnt_min_t (cnt_mt_s),
        .cnt_min_u (cnt_mu_s),
        .cnt_sec_t (cnt_st_s),
        .cnt_sec_u (cnt_su_s),
        .ld_min_t  (ld_mt_s),
        .ld_min_u  (ld_mu_s),
        .ld_sec_t  (ld_st_s),
        .ld_sec_u  (ld_su_s),
        .zero      (zero_s),
        .last      (last_s)
    );

    // Display source: the load register while editing, the live count otherwise.
    always_comb begin
        dsp_mt_s = cnt_mt_s;
        dsp_mu_s = cnt_mu_s;
        dsp_st_s = cnt_st_s;
        dsp_su_s = cnt_su_s;
        if (state_r == S_SET) begin
            dsp_mt_s = ld_mt_s;
            dsp_mu_s = ld_mu_s;
            dsp_st_s = ld_st_s;
            dsp_su_s = ld_su_s;
        end else begin
            dsp_mt_s = cnt_mt_s;
            dsp_mu_s = cnt_mu_s;
            dsp_st_s = cnt_st_s;
            dsp_su_s = cnt_su_s;
        end
    end

    time_display u_time_display (
        .sec_u (dsp_su_s),
        .sec_t (dsp_st_s),
        .min_u (dsp_mu_s),
        .min_t (dsp_mt_s),
        .seg1  (seg1_s),
        .seg2  (seg2_s),
        .seg3  (seg3_s),
        .seg4  (seg4_s)
    );

    // Segment output registers; reset shows the preset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg1_r <= seg_encode(P_SU);
            seg2_r <= seg_encode(P_ST);
            seg3_r <= seg_encode(P_MU);
            seg4_r <= seg_encode(P_MT);
        end else begin
            seg1_r <= seg1_s;
            seg2_r <= seg2_s;
            seg3_r <= seg3_s;
            seg4_r <= seg4_s;
        end
    end

    assign seg1  = seg1_r;
    assign seg2  = seg2_r;
    assign seg3  = seg3_r;
    assign seg4  = seg4_r;
    assign state = state_r;
    assign alarm = alarm_r;
    assign led   = led_r;

endmodule

// time_display: combinational BCD-to-7-segment decode of the four mm:ss digits.
module time_display
    import countdown_timer_with_alarm_pkg::*;
(
    input  bcd_t       sec_u,
    input  bcd_t       sec_t,
    input  bcd_t       min_u,
    input  bcd_t       min_t,
    output logic [6:0] seg1,
    output logic [6:0] seg2,
    output logic [6:0] seg3,
    output logic [6:0] seg4
);
    assign seg1 = seg_encode(sec_u);
    assign seg2 = seg_encode(sec_t);
    assign seg3 = seg_encode(min_u);
    assign seg4 = seg_encode(min_t);
endmodule
